// File: rtl/regfile_port_ctrl_if.sv
// Writeback and debug-load write requests into the register file port controller.
// The master drives the requests and the slave returns debug backpressure.
interface regfile_port_ctrl_if #(
  parameter int unsigned IDXW = 4,
  parameter int unsigned DW   = 16
);
  logic            wb_valid;
  logic [IDXW-1:0] wb_reg;
  logic [DW-1:0]   wb_data;
  logic            dbg_valid;
  logic            dbg_ready;
  logic [IDXW-1:0] dbg_reg;
  logic [DW-1:0]   dbg_data;

  modport master (
    output wb_valid, wb_reg, wb_data, dbg_valid, dbg_reg, dbg_data,
    input  dbg_ready
  );

  modport slave (
    input  wb_valid, wb_reg, wb_data, dbg_valid, dbg_reg, dbg_data,
    output dbg_ready
  );
endinterface

// File: rtl/regfile_port_ctrl.sv
// Register file access controller: read decode, single write port arbitration
// (writeback over buffered debug writes), bypass flags and debug starvation stall.
module regfile_port_ctrl #(
  parameter int unsigned NREG         = 16,
  parameter int unsigned IDXW         = 4,
  parameter int unsigned DW           = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  regfile_port_ctrl_if.slave  bus,
  input  logic [IDXW-1:0]     src_reg1,
  input  logic [IDXW-1:0]     src_reg2,
  output logic [NREG-1:0]     ReadEnable1,
  output logic [NREG-1:0]     ReadEnable2,
  output logic [NREG-1:0]     WriteReg,
  output logic [DW-1:0]       D,
  output logic                bypass1,
  output logic                bypass2,
  output logic                stall_req
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT) + 1;

  typedef enum logic [1:0] {StIdle, StWait, StForce} state_e;

  logic [IDXW-1:0] reg_q [2];
  logic [DW-1:0]   data_q [2];
  logic            rd_ptr_q, wr_ptr_q;
  logic [1:0]      fill_q, fill_d;
  logic            empty, full, push, pop, blocked;

  logic            sel_valid;
  logic [IDXW-1:0] sel_reg;
  logic [DW-1:0]   sel_data;

  state_e          state_q, state_d;
  logic [CntW-1:0] starve_q, starve_d;

  always_comb begin
    ReadEnable1 = '0;
    ReadEnable2 = '0;
    ReadEnable1[src_reg1] = 1'b1;
    ReadEnable2[src_reg2] = 1'b1;
  end

  assign empty         = (fill_q == 2'd0);
  assign full          = (fill_q == 2'd2);
  assign bus.dbg_ready = ~full;
  assign push          = bus.dbg_valid & ~full;
  assign pop           = ~bus.wb_valid & ~empty;
  assign blocked       = bus.wb_valid & ~empty;

  always_comb begin
    fill_d = fill_q;
    case ({push, pop})
      2'b10:   fill_d = fill_q + 2'd1;
      2'b01:   fill_d = fill_q - 2'd1;
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      fill_q   <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        reg_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      fill_q <= fill_d;
      if (push) begin
        reg_q[wr_ptr_q]  <= bus.dbg_reg;
        data_q[wr_ptr_q] <= bus.dbg_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // Reset gates the write port so a held wb_valid cannot pulse WriteReg.
  always_comb begin
    sel_valid = 1'b0;
    sel_reg   = '0;
    sel_data  = '0;
    if (!rst) begin
      if (bus.wb_valid) begin
        sel_valid = 1'b1;
        sel_reg   = bus.wb_reg;
        sel_data  = bus.wb_data;
      end else if (!empty) begin
        sel_valid = 1'b1;
        sel_reg   = reg_q[rd_ptr_q];
        sel_data  = data_q[rd_ptr_q];
      end
    end
  end

  always_comb begin
    WriteReg = '0;
    if (sel_valid && (sel_reg != '0)) begin
      WriteReg[sel_reg] = 1'b1;
    end
  end

  assign D       = sel_valid ? sel_data : '0;
  assign bypass1 = (|WriteReg) && (sel_reg == src_reg1);
  assign bypass2 = (|WriteReg) && (sel_reg == src_reg2);

  // The first blocked cycle moves IDLE->WAIT; FORCE follows once the count reaches LIMIT-1.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    unique case (state_q)
      StIdle: begin
        starve_d = '0;
        if (blocked) state_d = StWait;
      end
      StWait: begin
        if (empty) begin
          state_d  = StIdle;
          starve_d = '0;
        end else if (blocked) begin
          if (starve_q != '1) starve_d = starve_q + CntW'(1);
          if (starve_d >= CntW'(STARVE_LIMIT - 1)) state_d = StForce;
        end
      end
      StForce: begin
        if (pop) begin
          state_d  = StIdle;
          starve_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  assign stall_req = (state_q == StForce);

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Directed bench for regfile_port_ctrl with a scoreboard of pending debug writes.
module tb_regfile_port_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  src_reg1, src_reg2;
  logic [15:0] re1, re2, wr, d;
  logic        bp1, bp2, stall;

  typedef struct packed {
    logic [3:0]  r;
    logic [15:0] d;
  } entry_t;

  entry_t sb[$];
  int     n_vec = 0;
  int     n_err = 0;

  always #5 clk = ~clk;

  regfile_port_ctrl_if #(.IDXW(4), .DW(16)) bus ();

  regfile_port_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .src_reg1    (src_reg1),
    .src_reg2    (src_reg2),
    .ReadEnable1 (re1),
    .ReadEnable2 (re2),
    .WriteReg    (wr),
    .D           (d),
    .bypass1     (bp1),
    .bypass2     (bp2),
    .stall_req   (stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks one cycle at the falling edge, then advances to just past the next rising edge.
  task automatic cycle(input string tag, input logic exp_stall);
    logic        ev, exp_rdy;
    logic [3:0]  er;
    logic [15:0] ed, ewr, one;
    entry_t      e;
    @(negedge clk);
    one     = 16'h0001;
    exp_rdy = (sb.size() < 2);
    ev = 1'b0;
    er = 4'd0;
    ed = 16'h0;
    if (bus.wb_valid) begin
      ev = 1'b1;
      er = bus.wb_reg;
      ed = bus.wb_data;
    end else if (sb.size() > 0) begin
      e  = sb.pop_front();
      ev = 1'b1;
      er = e.r;
      ed = e.d;
    end
    ewr = (ev && er != 4'd0) ? (one << er) : 16'h0;
    chk({tag, ".WriteReg"}, wr, ewr);
    chk({tag, ".D"}, d, ev ? ed : 16'h0);
    chk({tag, ".bypass1"}, bp1, (ewr != 0) && (er == src_reg1));
    chk({tag, ".bypass2"}, bp2, (ewr != 0) && (er == src_reg2));
    chk({tag, ".dbg_ready"}, bus.dbg_ready, exp_rdy);
    chk({tag, ".stall_req"}, stall, exp_stall);
    chk({tag, ".ReadEnable1"}, re1, one << src_reg1);
    chk({tag, ".ReadEnable2"}, re2, one << src_reg2);
    if (bus.dbg_valid && exp_rdy) sb.push_back({bus.dbg_reg, bus.dbg_data});
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wb(input logic v, input logic [3:0] r, input logic [15:0] dat);
    bus.wb_valid = v;
    bus.wb_reg   = r;
    bus.wb_data  = dat;
  endtask

  task automatic drive_dbg(input logic v, input logic [3:0] r, input logic [15:0] dat);
    bus.dbg_valid = v;
    bus.dbg_reg   = r;
    bus.dbg_data  = dat;
  endtask

  initial begin
    rst      = 1'b1;
    src_reg1 = 4'd0;
    src_reg2 = 4'd0;
    drive_wb(1'b0, 4'd0, 16'h0);
    drive_dbg(1'b0, 4'd0, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.WriteReg", wr, 16'h0);
    chk("rst.dbg_ready", bus.dbg_ready, 1'b1);
    chk("rst.stall_req", stall, 1'b0);
    chk("rst.bypass1", bp1, 1'b0);
    rst = 1'b0;

    // Idle read decode
    src_reg1 = 4'd3;
    src_reg2 = 4'd15;
    cycle("idle", 1'b0);
    #1;
    chk("idle.re1_const", re1, 16'h0008);
    chk("idle.re2_const", re2, 16'h8000);

    // Writeback with bypass on port 1
    drive_wb(1'b1, 4'd5, 16'hBEEF);
    src_reg1 = 4'd5;
    src_reg2 = 4'd6;
    #1;
    chk("wb.WriteReg_const", wr, 16'h0020);
    chk("wb.bypass1_const", bp1, 1'b1);
    cycle("wb", 1'b0);

    // Single debug write through an idle port
    drive_wb(1'b0, 4'd0, 16'h0);
    drive_dbg(1'b1, 4'd2, 16'h1234);
    cycle("dbg_push", 1'b0);
    drive_dbg(1'b0, 4'd0, 16'h0);
    #1;
    chk("dbg_commit.WriteReg_const", wr, 16'h0004);
    cycle("dbg_commit", 1'b0);
    cycle("dbg_empty", 1'b0);

    // Starvation: two pushes behind continuous writeback
    drive_wb(1'b1, 4'd7, 16'h1111);
    drive_dbg(1'b1, 4'd9, 16'hAAAA);
    cycle("starve_a", 1'b0);
    drive_dbg(1'b1, 4'd10, 16'hBBBB);
    cycle("starve_b", 1'b0);
    drive_dbg(1'b0, 4'd0, 16'h0);
    cycle("starve_c", 1'b0);
    cycle("starve_d", 1'b0);
    cycle("starve_e", 1'b0);
    drive_wb(1'b0, 4'd0, 16'h0);
    cycle("drain_1", 1'b1);
    cycle("drain_2", 1'b0);
    cycle("drained", 1'b0);

    // R0 writes are discarded, debug entry still pops
    src_reg1 = 4'd0;
    drive_wb(1'b1, 4'd0, 16'hFFFF);
    drive_dbg(1'b1, 4'd0, 16'h5555);
    cycle("r0_wb", 1'b0);
    drive_wb(1'b0, 4'd0, 16'h0);
    drive_dbg(1'b0, 4'd0, 16'h0);
    cycle("r0_dbg", 1'b0);
    cycle("r0_after", 1'b0);

    // Reset with two entries buffered
    drive_wb(1'b1, 4'd3, 16'h3333);
    drive_dbg(1'b1, 4'd4, 16'h4444);
    cycle("pre_rst_a", 1'b0);
    drive_dbg(1'b1, 4'd5, 16'h5555);
    cycle("pre_rst_b", 1'b0);
    drive_dbg(1'b0, 4'd0, 16'h0);
    chk("pre_rst.full", bus.dbg_ready, 1'b0);
    rst = 1'b1;
    #1;
    chk("in_rst.dbg_ready", bus.dbg_ready, 1'b1);
    chk("in_rst.WriteReg", wr, 16'h0);
    chk("in_rst.D", d, 16'h0);
    chk("in_rst.stall_req", stall, 1'b0);
    sb.delete();
    @(posedge clk);
    #1;
    drive_wb(1'b0, 4'd0, 16'h0);
    rst = 1'b0;
    cycle("post_rst_1", 1'b0);
    cycle("post_rst_2", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_port_ctrl.md
Name: regfile_port_ctrl

Overview:
- Access controller for the 16-entry, 16-bit register file built from Register instances.
- Decodes read indices into one-hot read enables.
- Arbitrates the single write port between pipeline writeback (priority, no backpressure) and a debug/load port (valid/ready, 2-entry buffer).
- Flags same-cycle write/read hazards for bypass and forces a pipeline stall when debug writes starve.

Parameters:
NREG, 16, number of registers; one-hot enable width
IDXW, 4, register index width
DW, 16, data width
STARVE_LIMIT, 4, cycles a buffered debug write may wait before stall_req is raised

Ports:
clk  input  1  clock; the register file's write edge
rst  input  1  asynchronous reset, active-high
wb_valid  input  1  pipeline writeback valid this cycle
wb_reg  input  IDXW  writeback destination index
wb_data  input  DW  writeback data
dbg_valid  input  1  debug write request
dbg_ready  output  1  debug buffer can accept
dbg_reg  input  IDXW  debug destination index
dbg_data  input  DW  debug data
src_reg1  input  IDXW  read port 1 index
src_reg2  input  IDXW  read port 2 index
ReadEnable1  output  NREG  one-hot read enable, port 1
ReadEnable2  output  NREG  one-hot read enable, port 2
WriteReg  output  NREG  one-hot write enable (at most one bit set)
D  output  DW  write data to all registers
bypass1  output  1  port 1 reads the register being written this cycle; use D
bypass2  output  1  same, port 2
stall_req  output  1  pipeline must hold wb_valid low from the next cycle

Behaviour:
- Reset (async, while rst=1): buffer empty, starve counter 0, state IDLE, WriteReg=0, bypass1/2=0, stall_req=0, dbg_ready=1. ReadEnable1/2 remain a decode of src_reg1/2.
- Read decode:
  - ReadEnable1 = one-hot(src_reg1); ReadEnable2 = one-hot(src_reg2).
  - Both are purely combinational and always exactly one bit.
- Debug buffer (2-entry FIFO of {reg, data}):
  - dbg_ready = !full.
  - A push occurs on a clk edge with dbg_valid & dbg_ready.
  - Push and pop in the same cycle are legal; count is unchanged.
- Write arbitration (combinational, same cycle):
  - If wb_valid: write source = wb.
  - Otherwise, if the buffer is non-empty: source = buffer head, and the head pops at the edge.
  - Otherwise: no write.
  - D = selected data; D = 0 when there is no write.
  - WriteReg = one-hot(selected reg), or 0 if there is no write or the selected reg is 0. R0 stays zero.
  - A debug head targeting R0 still pops and its write is discarded.
- Latency:
  - wb commits at the edge ending its valid cycle.
  - A debug write pushed at edge E commits no earlier than the edge after E.
- Bypass:
  - bypassN = (WriteReg != 0) & (selected reg == src_regN).
  - This is combinational and never set for R0.
- Starvation FSM:
  - IDLE: counter cleared. Go to WAIT when the buffer is non-empty and wb_valid=1.
  - WAIT: counter increments each cycle a non-empty buffer is blocked by wb_valid. Return to IDLE if the buffer empties. Go to FORCE when counter reaches STARVE_LIMIT-1 while still blocked.
  - FORCE: stall_req=1 (registered). Return to IDLE, with stall_req=0 at the next edge, at the first edge where a buffered entry pops.
- Pipeline contract: wb_valid=0 in every cycle after a cycle in which stall_req=1.
- Counter width: clog2(STARVE_LIMIT)+1. The counter saturates and never wraps.
- Reset mid-operation: buffered debug writes are lost. No WriteReg pulse occurs during or at rst deassertion.

Test Plan:
- Reset, then idle → WriteReg=0, dbg_ready=1, stall_req=0; src_reg1=3, src_reg2=15 → ReadEnable1=16'h0008, ReadEnable2=16'h8000.
- wb_valid=1, wb_reg=5, wb_data=16'hBEEF, src_reg1=5 → WriteReg=16'h0020, D=16'hBEEF, bypass1=1, bypass2=0 (src_reg2=6).
- Debug push reg=2/data=16'h1234 while wb idle → dbg_ready stays 1; the next cycle WriteReg=16'h0004, D=16'h1234, and the buffer is then empty.
- Two debug pushes while wb_valid=1 continuously:
  - Buffer fills and dbg_ready=0 after the second push.
  - stall_req=1 after STARVE_LIMIT=4 blocked cycles.
  - Bench drops wb_valid; entries drain in order over 2 cycles and stall_req=0 after the first pop.
- wb_reg=0 with wb_valid=1, and a debug write to reg 0 → WriteReg=0, no bypass, and the debug entry still pops.
- Assert rst with 2 entries buffered → dbg_ready=1 and WriteReg=0 immediately (asynchronous); after release, no stale write occurs.
